// File: rtl/vpn_frame_builder.sv
// rtl/vpn_frame_builder.sv - store-and-forward packet framer: header, length, payload, optional XOR checksum.
// Checksum word is built only when VPN_FRAME_CHECKSUM_EN is defined.
module vpn_frame_builder #(
    parameter int         MAX_WORDS = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        out_eof,
    output logic        trunc
);
    localparam int AW = $clog2(MAX_WORDS);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] MAX_C = CW'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE, COLLECT, HDR, LEN, PAY
`ifdef VPN_FRAME_CHECKSUM_EN
        , CSUM
`endif
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  rd_q;
    logic [7:0]     seq_q;
    logic [15:0]    out_data_q;
    logic           out_valid_q;
    logic           out_sof_q;
    logic           out_eof_q;
    logic           trunc_q;
    logic           in_ready_q;
    logic [15:0]    mem [MAX_WORDS];
`ifdef VPN_FRAME_CHECKSUM_EN
    logic [15:0]    csum_q;
`endif

    logic          accept;
    logic          xfer;
    logic          closing;
    logic [CW-1:0] count_d;
    logic [AW-1:0] wr_idx;

    always_comb begin
        accept  = in_valid & in_ready_q;
        xfer    = out_valid_q & out_ready;
        count_d = (state_q == IDLE) ? CW'(1) : count_q + 1'b1;
        wr_idx  = (state_q == IDLE) ? '0 : count_q[AW-1:0];
        closing = accept & (in_last | (count_d == MAX_C));
    end

    // Buffer RAM is deliberately not reset; a reset only forgets the count.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_idx] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rd_q        <= '0;
            seq_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            trunc_q     <= 1'b0;
            in_ready_q  <= 1'b0;
`ifdef VPN_FRAME_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            trunc_q <= 1'b0;
            case (state_q)
                IDLE, COLLECT: begin
                    in_ready_q <= ~closing;
                    if (accept) begin
                        count_q <= count_d;
`ifdef VPN_FRAME_CHECKSUM_EN
                        csum_q  <= (state_q == IDLE) ? in_data : (csum_q ^ in_data);
`endif
                        if (closing) begin
                            state_q     <= HDR;
                            out_valid_q <= 1'b1;
                            out_data_q  <= {SYNC_BYTE, seq_q};
                            out_sof_q   <= 1'b1;
                            out_eof_q   <= 1'b0;
                            trunc_q     <= ~in_last;
                        end else begin
                            state_q <= COLLECT;
                        end
                    end
                end
                HDR: if (xfer) begin
                    state_q    <= LEN;
                    out_data_q <= {8'h00, 8'(count_q)};
                    out_sof_q  <= 1'b0;
                end
                LEN: if (xfer) begin
                    state_q    <= PAY;
                    out_data_q <= mem[0];
                    rd_q       <= CW'(1);
`ifndef VPN_FRAME_CHECKSUM_EN
                    out_eof_q  <= (count_q == CW'(1));
`endif
                end
                PAY: if (xfer) begin
                    if (rd_q == count_q) begin
`ifdef VPN_FRAME_CHECKSUM_EN
                        state_q    <= CSUM;
                        out_data_q <= csum_q;
                        out_eof_q  <= 1'b1;
`else
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        out_data_q  <= '0;
                        out_eof_q   <= 1'b0;
                        in_ready_q  <= 1'b1;
                        seq_q       <= seq_q + 8'd1;
`endif
                    end else begin
                        out_data_q <= mem[rd_q[AW-1:0]];
                        rd_q       <= rd_q + 1'b1;
`ifndef VPN_FRAME_CHECKSUM_EN
                        out_eof_q  <= ((rd_q + 1'b1) == count_q);
`endif
                    end
                end
`ifdef VPN_FRAME_CHECKSUM_EN
                CSUM: if (xfer) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    out_data_q  <= '0;
                    out_eof_q   <= 1'b0;
                    in_ready_q  <= 1'b1;
                    seq_q       <= seq_q + 8'd1;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign trunc     = trunc_q;
endmodule

// File: doc/vpn_frame_builder.md
VPN_FRAME_BUILDER -- requirements
Module: vpn_frame_builder

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 16: payload buffer depth in 16-bit words; legal values are powers of two from 2 to 128.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5: constant placed in the upper byte of the header word.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset is synchronous and active-low.
REQ-005 SHALL have port in_data, input, 16 bits: encrypted payload word from the upstream XOR stage.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-007 SHALL have port in_last, input, 1 bit: the current word is the final word of the packet.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-009 SHALL have port out_data, output, 16 bits: frame word.
REQ-010 SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit), out_sof (output, 1 bit) and out_eof (output, 1 bit).
REQ-011 SHALL have port trunc, output, 1 bit: one-cycle pulse when a packet is force-closed at MAX_WORDS.

Function
REQ-012 SHALL implement a store-and-forward framer: buffer one packet, then emit header, length, payload and optional checksum words.
REQ-013 SHALL implement FSM states IDLE, COLLECT, HDR, LEN, PAY and CSUM.
REQ-014 SHALL drive in_ready=1 only in IDLE and COLLECT; input is accepted only when in_valid and in_ready are both 1.
REQ-015 SHALL, on an accepted word in IDLE, store it at index 0 with count=1 and move to COLLECT, unless in_last=1.
REQ-016 SHALL, on an accepted word with in_last=1, or with count reaching MAX_WORDS, move to HDR on the next cycle; out_valid=1 in the cycle following acceptance.
REQ-017 SHALL, when count reaches MAX_WORDS without in_last, close the frame and pulse trunc=1 for exactly one cycle, in the cycle after acceptance.
REQ-018 SHALL output header word = {SYNC_BYTE, seq[7:0]}, then length word = {8'h00, count} with count in 1..MAX_WORDS, then payload words in arrival order.
REQ-019 SHALL follow the output handshake: a word transfers only when out_valid and out_ready are both 1; out_data, out_sof and out_eof hold stable while out_valid=1 and out_ready=0.
REQ-020 SHALL assert out_sof on the header word only, and out_eof on the final word of the frame only.
REQ-021 SHALL increment seq by 1 on transfer of the final frame word; seq wraps from 255 to 0.
REQ-022 SHALL return the FSM to IDLE after the final word transfers; the next input may be accepted the cycle after that transfer.
REQ-023 SHALL drive out_valid=0 in IDLE and COLLECT.
REQ-024 SHALL, when in_valid=0 in COLLECT, hold state with no timeout.

Reset
REQ-025 SHALL, when rst_n=0 at a rising clk edge in any state, force the FSM to IDLE and set count=0, seq=0 and checksum accumulator=0.
REQ-026 SHALL drive the following outputs during and immediately after reset: out_valid=0, out_sof=0, out_eof=0, out_data=16'h0000, trunc=0 and in_ready=0.
REQ-027 SHALL raise in_ready to 1 in the first cycle after rst_n returns to 1.
REQ-028 SHALL discard any buffered packet on reset; buffer RAM contents need not be cleared.

Configuration
REQ-029 SHALL, with VPN_FRAME_CHECKSUM_EN defined, append a CSUM word equal to the XOR of all payload words and assert out_eof on that CSUM word.
REQ-030 SHALL, with VPN_FRAME_CHECKSUM_EN undefined, omit the CSUM state and accumulator, and assert out_eof on the last payload word.

Verification
REQ-031 SHALL verify that a 3-word packet 16'h1111, 16'h2222, 16'h4444 (last on third) after reset produces 16'hA500, 16'h0003, 16'h1111, 16'h2222, 16'h4444, 16'h7777 (checksum enabled), with sof on word 1 and eof on word 6.
REQ-032 SHALL verify that out_ready=0 for 5 cycles during the LEN word keeps out_data=16'h0003 and out_valid=1 stable, and that in_ready stays 0 throughout.
REQ-033 SHALL verify that 16 words with in_last never asserted (MAX_WORDS=16) produce a single-cycle trunc pulse, length word 16'h0010, and in_ready=0 after the 16th word.
REQ-034 SHALL verify that 256 single-word packets produce header seq values 0x00..0xFF, and that the 257th header equals 16'hA500.
REQ-035 SHALL verify that rst_n=0 for 1 cycle during PAY results in out_valid=0 the next cycle, and that the following packet's header equals 16'hA500.
REQ-036 SHALL verify that a single-word packet 16'hBEEF with the checksum macro undefined produces 16'hA500, 16'h0001, 16'hBEEF, with eof on 16'hBEEF.
